// File: rtl/screen_render.sv
// Display-scan driver: time-multiplexes an 8x16 bitmap and eight hex digits
// onto the 32-bit GPIO0 bus, one row and one seven-segment digit per scan slot.
module screen_render #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] sev_seg,
    input  logic [15:0] row0,
    input  logic [15:0] row1,
    input  logic [15:0] row2,
    input  logic [15:0] row3,
    input  logic [15:0] row4,
    input  logic [15:0] row5,
    input  logic [15:0] row6,
    input  logic [15:0] row7,
    output logic [31:0] gpio_out
);

    localparam int              PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [31:0]     RESET_BUS = 32'h7F00_0000;

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic          in_blank;
    logic [15:0]   row_sel;
    logic [3:0]    digit;
    logic [7:0]    enable;
    logic [31:0]   next_bus;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // A zero-length blank phase would otherwise be a constant compare against zero.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
            assign in_blank = (prescaler < BLANK_LIM);
        end
    endgenerate

    always_comb begin
        row_sel = 16'h0000;
        case (idx)
            3'd0: row_sel = row0;
            3'd1: row_sel = row1;
            3'd2: row_sel = row2;
            3'd3: row_sel = row3;
            3'd4: row_sel = row4;
            3'd5: row_sel = row5;
            3'd6: row_sel = row6;
            default: row_sel = row7;
        endcase
    end

    assign digit  = sev_seg[{idx, 2'b00} +: 4];
    assign enable = 8'b0000_0001 << idx;

    // Marker tracks idx in both phases; only the lower 31 bits change with the phase.
    always_comb begin
        next_bus = {(idx == 3'd0), 7'h7F, 8'h00, 16'h0000};
        if (!in_blank) begin
            next_bus[30:0] = {hex_to_seg(digit), enable, row_sel};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            idx       <= 3'd0;
            gpio_out  <= RESET_BUS;
        end else begin
            gpio_out <= next_bus;
            if (prescaler == PRE_MAX) begin
                prescaler <= '0;
                idx       <= idx + 3'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_screen_render.sv
// Scoreboard bench for screen_render: two instances (blanking and no blanking)
// share stimulus; expected buses are queued per edge and checked by a monitor.
module tb_screen_render;

    logic        clock;
    logic        reset_n;
    logic [31:0] sev_seg;
    logic [15:0] rows [8];
    logic [31:0] gpio_a;
    logic [31:0] gpio_b;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int          checks = 0;
    int          errors = 0;
    int          k = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    screen_render #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .sev_seg(sev_seg),
        .row0(rows[0]), .row1(rows[1]), .row2(rows[2]), .row3(rows[3]),
        .row4(rows[4]), .row5(rows[5]), .row6(rows[6]), .row7(rows[7]),
        .gpio_out(gpio_a)
    );

    screen_render #(.SCAN_DIV(8), .BLANK_CYCLES(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .sev_seg(sev_seg),
        .row0(rows[0]), .row1(rows[1]), .row2(rows[2]), .row3(rows[3]),
        .row4(rows[4]), .row5(rows[5]), .row6(rows[6]), .row7(rows[7]),
        .gpio_out(gpio_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected bus for the k-th edge after release, straight from the edge numbering.
    function automatic logic [31:0] exp_bus(input int edge_k, input int blank);
        int          pres;
        int          slot;
        logic [31:0] b;
        logic [3:0]  nib;
        logic [7:0]  en;
        pres  = (edge_k - 1) % 8;
        slot  = ((edge_k - 1) / 8) % 8;
        nib   = sev_seg[slot*4 +: 4];
        en    = 8'(1 << slot);
        b[31] = (slot == 0);
        if (pres < blank) b[30:0] = {7'h7F, 24'h000000};
        else              b[30:0] = {hex_tab[nib], en, rows[slot]};
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s edge=%0d got=%h expected=%h", name, k, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        k++;
        q_a.push_back(exp_bus(k, 2));
        q_b.push_back(exp_bus(k, 0));
        @(negedge clock);
    endtask

    // Monitor: the bus changes on every edge (or async reset), so each event is a presentation.
    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            #1;
            if (q_a.size() > 0) begin
                checkOutput("bus_a", gpio_a, q_a.pop_front());
                checkOutput("bus_b", gpio_b, q_b.pop_front());
                checkOutput("onehot_a", 32'($countones(gpio_a[23:16]) <= 1), 32'd1);
                checkOutput("onehot_b", 32'($countones(gpio_b[23:16]) <= 1), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n = 1'b0;
        sev_seg = 32'h7654_3210;
        for (int i = 0; i < 8; i++) rows[i] = 16'(16'h0001 << i);

        // Reset value held across a clock edge
        @(negedge clock);
        q_a.push_back(32'h7F00_0000);
        q_b.push_back(32'h7F00_0000);
        @(negedge clock);

        // Full frame plus wrap back into active slot 0
        reset_n = 1'b1;
        k = 0;
        for (int n = 0; n < 8*8 + 3; n++) applyStimulus();

        // Live row update in the middle of slot 3
        rows[3] = 16'hAAAA;
        for (int n = 0; n < 64; n++) begin
            if (k % 64 == 3*8 + 4) rows[3] = 16'h5555;
            applyStimulus();
        end

        // Hex sweep: new nibble for digit 0 on every slot-0 active edge of dut_a
        begin
            int nib = 0;
            for (int n = 0; n < 192; n++) begin
                if ((k % 64) >= 2 && (k % 64) < 8 && nib < 16) begin
                    sev_seg[3:0] = 4'(nib);
                    nib++;
                end
                applyStimulus();
            end
        end

        // Asynchronous reset mid-slot, then restart at slot 0
        for (int n = 0; n < 5; n++) applyStimulus();
        #2;
        q_a.push_back(32'h7F00_0000);
        q_b.push_back(32'h7F00_0000);
        reset_n = 1'b0;
        @(negedge clock);
        q_a.push_back(32'h7F00_0000);
        q_b.push_back(32'h7F00_0000);
        @(negedge clock);
        reset_n = 1'b1;
        k = 0;
        sev_seg = 32'hFEDC_BA98;
        for (int n = 0; n < 12; n++) applyStimulus();

        @(posedge clock);
        #3;
        checkOutput("queue_drained", 32'(q_a.size() + q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
